// File: rtl/flappy_bird_core_if.sv
// Signal bundle between the flappy-bird game core and its neighbours.
// The master drives flap/crash requests; the slave (the core) returns game state.
interface flappy_bird_core_if;
    logic       press;
    logic       game_over;
    logic       ongoing;
    logic [7:0] bird;
    logic       fell;
    logic [2:0] rnd;

    modport master (
        output press, game_over,
        input  ongoing, bird, fell, rnd
    );

    modport slave (
        input  press, game_over,
        output ongoing, bird, fell, rnd
    );
endinterface

// File: rtl/flappy_bird_core.sv
// Game core for the 8x8 LED flappy-bird: run/idle flag, one-hot bird row with
// gravity, and a free-running 3-bit LFSR for the pipe gap. Every output is a register.
module flappy_bird_core #(
    parameter int START_ROW   = 4,
    parameter int FALL_PERIOD = 4
) (
    input logic               clk,
    input logic               reset,
    flappy_bird_core_if.slave bus
);
    localparam int              CNT_W     = (FALL_PERIOD > 1) ? $clog2(FALL_PERIOD) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(FALL_PERIOD - 1);
    localparam logic [7:0]       BIRD_RST  = 8'(1 << START_ROW);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    logic             r_ongoing;
    logic [7:0]       r_bird;
    logic             r_fell;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_rnd;
    logic             w_active;

    // The bird is frozen until the game runs, after a crash, and once it has fallen.
    assign w_active = r_ongoing & ~bus.game_over & ~r_fell;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_ongoing <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.press) begin
                        r_state   <= S_RUN;
                        r_ongoing <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_state   <= S_RUN;
                    r_ongoing <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bird <= BIRD_RST;
            r_fell <= 1'b0;
            r_cnt  <= '0;
        end else if (w_active) begin
            if (bus.press) begin
                // A flap discards any gravity tick due on the same cycle.
                if (!r_bird[7]) begin
                    r_bird <= r_bird << 1;
                end
                r_cnt <= '0;
            end else if (r_cnt == TICK_LAST) begin
                r_bird <= r_bird >> 1;
                r_cnt  <= '0;
                if (r_bird[0]) begin
                    r_fell <= 1'b1;
                end
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Period-7 LFSR; 3'b111 is the lockup state and cannot be reached from reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rnd <= 3'b000;
        end else begin
            r_rnd <= {r_rnd[1:0], ~(r_rnd[2] ^ r_rnd[1])};
        end
    end

    assign bus.ongoing = r_ongoing;
    assign bus.bird    = r_bird;
    assign bus.fell    = r_fell;
    assign bus.rnd     = r_rnd;
endmodule

// File: tb/tb_flappy_bird_core.sv
// Directed and randomized bench for flappy_bird_core against a row/tick-count
// model of the game rules, with the LFSR predicted from its documented sequence.
module tb_flappy_bird_core;
    localparam int START_ROW   = 4;
    localparam int FALL_PERIOD = 4;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    flappy_bird_core_if bus ();

    flappy_bird_core #(
        .START_ROW   (START_ROW),
        .FALL_PERIOD (FALL_PERIOD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: bird as a row number (-1 once fallen), gravity as a tick
    // count, and the LFSR as a position within its known period-7 sequence.
    bit         m_ongoing;
    int         m_row;
    int         m_ticks;
    int         m_idx;
    logic [2:0] lfsr_seq [7];

    function automatic void model_reset();
        m_ongoing = 1'b0;
        m_row     = START_ROW;
        m_ticks   = 0;
        m_idx     = 0;
    endfunction

    function automatic void model_step(input bit p, input bit g);
        bit active;
        active = m_ongoing && !g && (m_row >= 0);
        if (!m_ongoing && p) m_ongoing = 1'b1;
        if (active) begin
            if (p) begin
                m_row   = (m_row < 7) ? m_row + 1 : 7;
                m_ticks = 0;
            end else if (m_ticks == FALL_PERIOD - 1) begin
                m_row   = m_row - 1;
                m_ticks = 0;
            end else begin
                m_ticks = m_ticks + 1;
            end
        end
        m_idx = (m_idx + 1) % 7;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ctx);
        logic [7:0] exp_bird;
        exp_bird = (m_row < 0) ? 8'h00 : 8'(1 << m_row);
        check({ctx, ".ongoing"}, 32'(bus.ongoing), 32'(m_ongoing));
        check({ctx, ".bird"},    32'(bus.bird),    32'(exp_bird));
        check({ctx, ".fell"},    32'(bus.fell),    32'(m_row < 0));
        check({ctx, ".rnd"},     32'(bus.rnd),     32'(lfsr_seq[m_idx]));
    endtask

    // Called at a negedge: drive inputs, let one posedge pass, check at the next negedge.
    task automatic cycle(input string ctx, input bit p, input bit g);
        bus.press     = p;
        bus.game_over = g;
        @(posedge clk);
        model_step(p, g);
        @(negedge clk);
        check_all(ctx);
    endtask

    task automatic hold_reset();
        reset = 1'b0;
        bus.press     = 1'b0;
        bus.game_over = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        reset = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        lfsr_seq = '{3'b000, 3'b001, 3'b011, 3'b110, 3'b101, 3'b010, 3'b100};
        reset = 1'b0;
        bus.press = 1'b0;
        bus.game_over = 1'b0;
        hold_reset();
        check("reset.bird_const", 32'(bus.bird), 32'h10);

        for (int i = 0; i < 8; i++) cycle("idle_lfsr", 1'b0, 1'b0);
        check("lfsr_wrap", 32'(bus.rnd), 32'(3'b001));
        for (int i = 0; i < 12; i++) cycle("idle_hold", 1'b0, 1'b0);

        cycle("start", 1'b1, 1'b0);
        check("start.bird_const", 32'(bus.bird), 32'h10);

        for (int i = 0; i < 20; i++) cycle("fall", 1'b0, 1'b0);
        check("fell_const", 32'(bus.fell), 32'h1);
        for (int i = 0; i < 6; i++) cycle("fell_hold", i[0], 1'b0);

        hold_reset();
        cycle("restart", 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cycle("ceiling", 1'b1, 1'b0);
        check("ceiling_const", 32'(bus.bird), 32'h80);
        for (int i = 0; i < 3; i++) cycle("post_flap_hold", 1'b0, 1'b0);
        cycle("post_flap_drop", 1'b0, 1'b0);
        check("counter_cleared", 32'(bus.bird), 32'h40);

        cycle("pre_crash", 1'b0, 1'b0);
        cycle("pre_crash", 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cycle("crash_freeze", 1'(i % 3 == 0), 1'b1);
        cycle("resume", 1'b0, 1'b0);
        check("resume_hold", 32'(bus.bird), 32'h40);
        cycle("resume", 1'b0, 1'b0);
        check("resume_drop", 32'(bus.bird), 32'h20);

        for (int i = 0; i < 200; i++)
            cycle("rand_a", 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0));

        // Reset pulled between edges must act without a clock.
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_all("async_reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        cycle("restart_after_reset", 1'b0, 1'b0);
        cycle("restart_after_reset", 1'b1, 1'b0);
        check("restart_ongoing", 32'(bus.ongoing), 32'h1);

        for (int i = 0; i < 300; i++)
            cycle("rand_b", 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 9) == 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
